// File: rtl/pmp_dmp_if.sv
// Access-side bundle of the PMP/DMP checker: the access under test, its
// combinational decision and the registered fault-capture outputs.
interface pmp_dmp_if #(
  parameter int unsigned PLEN = 56
);
  logic [PLEN-1:0] addr_i;
  logic [2:0]      access_type_i;
  logic [1:0]      priv_lvl_i;
  logic [1:0]      expected_dom_i;
  logic            access_valid_i;
  logic            allow_o;
  logic            fault_o;
  logic [PLEN-1:0] fault_addr_o;

  modport master (
    output addr_i, access_type_i, priv_lvl_i, expected_dom_i, access_valid_i,
    input  allow_o, fault_o, fault_addr_o
  );

  modport slave (
    input  addr_i, access_type_i, priv_lvl_i, expected_dom_i, access_valid_i,
    output allow_o, fault_o, fault_addr_o
  );
endinterface

// File: rtl/pmp_dmp.sv
// Physical/domain memory protection checker: per-entry address match with
// R/W/X rights plus JIT-domain ownership, and a registered fault capture.
module pmp_dmp #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_i,
  input  logic [NR_ENTRIES-1:0][7:0]           pmpconf_i,
  input  logic [NR_ENTRIES-1:0][1:0]           dmpconf_i,
  pmp_dmp_if.slave                             acc
);

  typedef struct packed {
    logic       locked;
    logic [1:0] reserved;
    logic [1:0] addr_mode;
    logic [2:0] access_type;
  } pmpcfg_t;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_TOR   = 2'd1;
  localparam logic [1:0] MODE_NA4   = 2'd2;
  localparam logic [1:0] MODE_NAPOT = 2'd3;
  localparam logic [1:0] PRIV_M     = 2'd3;
  localparam logic [1:0] DOMI       = 2'd3;

  function automatic logic [PLEN-1:0] ext_addr(input logic [PMP_LEN-1:0] c);
    return PLEN'({c, 2'b00});
  endfunction

  function automatic logic na4_match(input logic [PLEN-1:0] a,
                                     input logic [PMP_LEN-1:0] c);
    logic [PLEN-1:0] m;
    m = PLEN'({{PMP_LEN{1'b1}}, 2'b00});
    return ((a ^ ext_addr(c)) & m) == '0;
  endfunction

  // Region size follows the trailing-ones run; only bits above k+2 are compared.
  function automatic logic napot_match(input logic [PLEN-1:0] a,
                                       input logic [PMP_LEN-1:0] c);
    int              k;
    logic            run;
    logic [PLEN-1:0] m;
    k   = 0;
    run = 1'b1;
    for (int b = 0; b < int'(PMP_LEN); b++) begin
      if (run && c[b]) k++;
      else run = 1'b0;
    end
    for (int b = 0; b < int'(PLEN); b++) m[b] = (b > k + 2);
    return (&c) || (((a ^ ext_addr(c)) & m) == '0);
  endfunction

  logic [NR_ENTRIES-1:0][PLEN-1:0] tor_lo;
  logic [NR_ENTRIES-1:0]           match;
  logic                            hit;
  pmpcfg_t                         sel_cfg;
  logic [1:0]                      sel_dom;
  logic                            pmp_ok;
  logic                            dmp_ok;
  logic                            allow;
  logic                            unused_rsvd;

  always_comb begin
    tor_lo    = '0;
    for (int i = 1; i < int'(NR_ENTRIES); i++) tor_lo[i] = ext_addr(conf_addr_i[i-1]);
  end

  always_comb begin
    pmpcfg_t cfg;
    match = '0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      cfg = pmpcfg_t'(pmpconf_i[i]);
      unique case (cfg.addr_mode)
        MODE_OFF:   match[i] = 1'b0;
        MODE_TOR:   match[i] = (acc.addr_i >= tor_lo[i]) &&
                               (acc.addr_i < ext_addr(conf_addr_i[i]));
        MODE_NA4:   match[i] = na4_match(acc.addr_i, conf_addr_i[i]);
        MODE_NAPOT: match[i] = napot_match(acc.addr_i, conf_addr_i[i]);
        default:    match[i] = 1'b0;
      endcase
    end
  end

  // Walk from the top so the lowest-index matching entry is the one left selected.
  always_comb begin
    hit     = 1'b0;
    sel_cfg = '0;
    sel_dom = '0;
    for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        sel_cfg = pmpcfg_t'(pmpconf_i[i]);
        sel_dom = dmpconf_i[i];
      end
    end
  end

  always_comb begin
    unused_rsvd = 1'b0;
    for (int i = 0; i < int'(NR_ENTRIES); i++)
      unused_rsvd = unused_rsvd ^ (^pmpconf_i[i][6:5]);
  end

  assign pmp_ok = (acc.access_type_i & sel_cfg.access_type) == acc.access_type_i;
  assign dmp_ok = (acc.expected_dom_i == DOMI) || (sel_dom == DOMI) ||
                  (acc.expected_dom_i == sel_dom);

  always_comb begin
    allow = 1'b0;
    if (acc.priv_lvl_i == PRIV_M) allow = !hit || !sel_cfg.locked || (pmp_ok && dmp_ok);
    else                          allow = hit && pmp_ok && dmp_ok;
  end

  assign acc.allow_o = allow;

  // Stage p1: capture of denied, qualified accesses
  logic            vld_p1;
  logic [PLEN-1:0] fault_addr_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1        <= 1'b0;
      fault_addr_p1 <= '0;
    end else begin
      vld_p1 <= acc.access_valid_i & ~allow;
      if (acc.access_valid_i & ~allow) fault_addr_p1 <= acc.addr_i;
    end
  end

  assign acc.fault_o      = vld_p1;
  assign acc.fault_addr_o = fault_addr_p1;

endmodule

// File: tb/tb_pmp_dmp.sv
// Bench for pmp_dmp: table of access vectors checked against allow_o, with a
// scoreboard queue of expected fault-stage outputs, plus reset/back-to-back sequences.
module tb_pmp_dmp;
  localparam int unsigned PLEN    = 16;
  localparam int unsigned PMP_LEN = 13;
  localparam int unsigned NR      = 1;

  localparam logic [1:0] U = 2'd0, M = 2'd3;
  localparam logic [2:0] R = 3'b001, W = 3'b010, X = 3'b100;
  localparam logic [7:0] NAPOT_RWX = 8'h1F, NAPOT_X = 8'h1C, NAPOT_RX = 8'h1D;
  localparam logic [7:0] OFF_RWX = 8'h07, LOCK_NAPOT_X = 8'h9C, LOCK_NAPOT_RWX = 8'h9F;
  localparam logic [7:0] TOR_RWX = 8'h0F, NA4_RWX = 8'h17;

  typedef struct {
    logic [1:0]         priv;
    logic [2:0]         acc;
    logic [1:0]         edom;
    logic [7:0]         cfg;
    logic [1:0]         ddom;
    logic [PMP_LEN-1:0] conf;
    logic [PLEN-1:0]    addr;
    logic               exp_allow;
  } vec_t;

  typedef struct {
    logic            fault;
    logic [PLEN-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NR-1:0][PMP_LEN-1:0] conf_addr;
  logic [NR-1:0][7:0]         pmpconf;
  logic [NR-1:0][1:0]         dmpconf;

  pmp_dmp_if #(.PLEN(PLEN)) acc_if ();

  pmp_dmp #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .conf_addr_i (conf_addr),
    .pmpconf_i   (pmpconf),
    .dmpconf_i   (dmpconf),
    .acc         (acc_if)
  );

  always #5 clk = ~clk;

  vec_t            vecs[$];
  exp_t            sb[$];
  int              n_pass  = 0;
  int              n_total = 0;
  logic [PLEN-1:0] last_fault_addr = '0;

  function automatic vec_t mk(logic [1:0] priv, logic [2:0] a, logic [1:0] edom,
                              logic [7:0] cfg, logic [1:0] ddom,
                              logic [PMP_LEN-1:0] conf, logic [PLEN-1:0] addr,
                              logic exp_allow);
    vec_t v;
    v.priv = priv; v.acc = a; v.edom = edom; v.cfg = cfg; v.ddom = ddom;
    v.conf = conf; v.addr = addr; v.exp_allow = exp_allow;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, got, want);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t v, input logic valid);
    acc_if.priv_lvl_i     = v.priv;
    acc_if.access_type_i  = v.acc;
    acc_if.expected_dom_i = v.edom;
    acc_if.addr_i         = v.addr;
    acc_if.access_valid_i = valid;
    pmpconf[0]            = v.cfg;
    dmpconf[0]            = v.ddom;
    conf_addr[0]          = v.conf;
  endtask

  task automatic run_vec(input vec_t v, input logic valid, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    drive(v, valid);
    #1;
    check("allow", idx, 32'(acc_if.allow_o), 32'(v.exp_allow));
    e.fault = valid & ~v.exp_allow;
    if (e.fault) last_fault_addr = v.addr;
    e.addr = last_fault_addr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", idx, 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("fault", idx, 32'(acc_if.fault_o), 32'(g.fault));
      check("fault_addr", idx, 32'(acc_if.fault_addr_o), 32'(g.addr));
    end
  endtask

  initial begin
    vec_t den;
    vec_t ok;
    for (int ed = 0; ed < 4; ed++)
      for (int dd = 0; dd < 4; dd++)
        vecs.push_back(mk(U, R, 2'(ed), NAPOT_RWX, 2'(dd), 13'h065F, 16'h19BA,
                          (ed == 3) || (dd == 3) || (ed == dd)));
    for (int ed = 0; ed < 4; ed++)
      for (int dd = 0; dd < 4; dd++)
        vecs.push_back(mk(U, R, 2'(ed), NAPOT_X, 2'(dd), 13'h065F, 16'h19BA, 1'b0));
    vecs.push_back(mk(U, R, 0, OFF_RWX,        0, 13'h065F, 16'h19BA, 1'b0));
    vecs.push_back(mk(M, R, 0, OFF_RWX,        0, 13'h065F, 16'h19BA, 1'b1));
    vecs.push_back(mk(U, R, 0, NAPOT_RWX,      0, 13'h065F, 16'h1A00, 1'b0));
    vecs.push_back(mk(M, R, 0, NAPOT_RWX,      0, 13'h065F, 16'h1A00, 1'b1));
    vecs.push_back(mk(U, R, 0, NAPOT_RWX,      0, 13'h065F, 16'h18FF, 1'b0));
    vecs.push_back(mk(U, R, 0, NAPOT_RWX,      0, 13'h065F, 16'h1900, 1'b1));
    vecs.push_back(mk(U, R, 0, NAPOT_RWX,      0, 13'h065F, 16'h19FF, 1'b1));
    vecs.push_back(mk(M, R, 0, LOCK_NAPOT_X,   0, 13'h065F, 16'h19BA, 1'b0));
    vecs.push_back(mk(M, R, 0, NAPOT_X,        0, 13'h065F, 16'h19BA, 1'b1));
    vecs.push_back(mk(M, R, 0, LOCK_NAPOT_RWX, 1, 13'h065F, 16'h19BA, 1'b0));
    vecs.push_back(mk(M, R, 0, NAPOT_RWX,      1, 13'h065F, 16'h19BA, 1'b1));
    vecs.push_back(mk(U, W, 0, NAPOT_RX,       0, 13'h065F, 16'h19BA, 1'b0));
    vecs.push_back(mk(U, X, 0, NAPOT_RX,       0, 13'h065F, 16'h19BA, 1'b1));
    vecs.push_back(mk(U, R, 0, TOR_RWX,        0, 13'h0680, 16'h19FC, 1'b1));
    vecs.push_back(mk(U, R, 0, TOR_RWX,        0, 13'h0680, 16'h1A00, 1'b0));
    vecs.push_back(mk(U, R, 0, TOR_RWX,        0, 13'h0680, 16'h0000, 1'b1));
    vecs.push_back(mk(U, R, 0, NA4_RWX,        0, 13'h066E, 16'h19B7, 1'b0));
    vecs.push_back(mk(U, R, 0, NA4_RWX,        0, 13'h066E, 16'h19B8, 1'b1));
    vecs.push_back(mk(U, R, 0, NA4_RWX,        0, 13'h066E, 16'h19BB, 1'b1));
    vecs.push_back(mk(U, R, 0, NA4_RWX,        0, 13'h066E, 16'h19BC, 1'b0));
    vecs.push_back(mk(U, R, 0, NAPOT_RWX,      0, 13'h1FFF, 16'h0000, 1'b1));
    vecs.push_back(mk(U, R, 0, NAPOT_RWX,      0, 13'h1FFF, 16'hFFFF, 1'b1));

    rst_ni = 1'b1;
    drive(mk(U, R, 0, OFF_RWX, 0, 13'h0, 16'h0, 1'b0), 1'b0);
    #3 rst_ni = 1'b0;
    #1;
    check("rst_fault", 0, 32'(acc_if.fault_o), 32'd0);
    check("rst_fault_addr", 0, 32'(acc_if.fault_addr_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_ni = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], (i % 5) != 4, i);

    den = mk(U, R, 0, NAPOT_RWX, 0, 13'h065F, 16'h1A00, 1'b0);
    ok  = mk(U, R, 0, NAPOT_RWX, 0, 13'h065F, 16'h19BA, 1'b1);
    run_vec(den, 1'b1, 100);
    den.addr = 16'h1A04;
    run_vec(den, 1'b1, 101);
    run_vec(ok,  1'b1, 102);
    run_vec(den, 1'b0, 103);
    den.addr = 16'h1A08;
    run_vec(den, 1'b1, 104);

    rst_ni = 1'b0;
    #1;
    check("midrst_fault", 0, 32'(acc_if.fault_o), 32'd0);
    check("midrst_fault_addr", 0, 32'(acc_if.fault_addr_o), 32'd0);
    check("midrst_allow", 0, 32'(acc_if.allow_o), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_fault", 0, 32'(acc_if.fault_o), 32'd0);
    @(negedge clk) rst_ni = 1'b1;
    last_fault_addr = '0;
    sb.delete();

    ok.priv = U;
    ok.addr = 16'h19BA;
    ok.cfg  = NAPOT_X;
    ok.exp_allow = 1'b0;
    run_vec(ok, 1'b1, 105);
    run_vec(ok, 1'b0, 106);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
